// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/exec/mem/wb sequencer for the 16-bit four-register core
// Owns pc and instruction register; shares one memory port between fetch and LD/ST.
module core_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        run_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [15:0] mem_rdata_i,
    output logic [15:0] instr_o,
    input  logic [1:0]  next_pc_sel_i,
    input  logic        reg_in_source_i,
    input  logic        reg_in_en_i,
    input  logic        d_we_i,
    input  logic        d_addr_sel_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] reg_a_i,
    input  logic [15:0] reg_b_i,
    output logic        reg_we_o,
    output logic [15:0] load_data_o,
    output logic [15:0] pc_o,
    output logic        fault_o
);

    typedef enum logic [2:0] {
        S_HALT,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_FAULT
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_n, boundary;
    logic [15:0] pc, pc_n;
    logic [15:0] ir, ir_n;
    logic [15:0] load_q, load_n;
    logic [15:0] daddr, daddr_n;
    logic [15:0] wdata_q, wdata_n;
    logic [15:0] wait_cnt, wait_cnt_n;
    logic        is_ld, is_ld_n;
    logic        req_q, req_n;
    logic        we_q, we_n;
    logic [15:0] addr_q, addr_n;
    logic [15:0] wd_q, wd_n;
    logic [15:0] data_addr;
    logic        reg_we;
    logic        timed_out;

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        ir_n      = ir;
        load_n    = load_q;
        daddr_n   = daddr;
        wdata_n   = wdata_q;
        is_ld_n   = is_ld;
        reg_we    = 1'b0;
        boundary  = run_i ? S_FETCH : S_HALT;
        data_addr = d_addr_sel_i ? reg_a_i : addr_i;
        timed_out = (TIMEOUT != 0) && !mem_ack_i && (wait_cnt == WAIT_LAST);

        case (state)
            S_HALT: begin
                if (run_i) state_n = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack_i) begin
                    ir_n    = mem_rdata_i;
                    state_n = S_EXEC;
                end else if (timed_out) begin
                    state_n = S_FAULT;
                end
            end
            S_EXEC: begin
                if (d_we_i) begin
                    daddr_n = data_addr;
                    wdata_n = reg_b_i;
                    is_ld_n = 1'b0;
                    state_n = S_MEM;
                end else if (reg_in_source_i) begin
                    daddr_n = data_addr;
                    is_ld_n = 1'b1;
                    state_n = S_MEM;
                end else begin
                    reg_we = reg_in_en_i;
                    if (next_pc_sel_i[1])      pc_n = reg_a_i;
                    else if (next_pc_sel_i[0]) pc_n = pc + addr_i;
                    else                       pc_n = pc + 16'd1;
                    state_n = boundary;
                end
            end
            S_MEM: begin
                if (mem_ack_i) begin
                    if (is_ld) begin
                        load_n  = mem_rdata_i;
                        state_n = S_WB;
                    end else begin
                        pc_n    = pc + 16'd1;
                        state_n = boundary;
                    end
                end else if (timed_out) begin
                    state_n = S_FAULT;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                pc_n    = pc + 16'd1;
                state_n = boundary;
            end
            S_FAULT: state_n = S_FAULT;
            default: state_n = S_HALT;
        endcase

        // Bus outputs are registered from the state being entered so they never glitch.
        req_n  = (state_n == S_FETCH) || (state_n == S_MEM);
        we_n   = (state_n == S_MEM) && !is_ld_n;
        addr_n = (state_n == S_FETCH) ? pc_n : ((state_n == S_MEM) ? daddr_n : 16'h0000);
        wd_n   = (state_n == S_MEM) ? wdata_n : 16'h0000;

        if (req_n && (state_n != state)) wait_cnt_n = 16'h0000;
        else if (req_q && !mem_ack_i)    wait_cnt_n = wait_cnt + 16'd1;
        else                             wait_cnt_n = wait_cnt;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= S_HALT;
            pc       <= RESET_PC;
            ir       <= 16'h0000;
            load_q   <= 16'h0000;
            daddr    <= 16'h0000;
            wdata_q  <= 16'h0000;
            is_ld    <= 1'b0;
            wait_cnt <= 16'h0000;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wd_q     <= 16'h0000;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            load_q   <= load_n;
            daddr    <= daddr_n;
            wdata_q  <= wdata_n;
            is_ld    <= is_ld_n;
            wait_cnt <= wait_cnt_n;
            req_q    <= req_n;
            we_q     <= we_n;
            addr_q   <= addr_n;
            wd_q     <= wd_n;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wd_q;
    assign instr_o     = ir;
    assign load_data_o = load_q;
    assign pc_o        = pc;
    assign reg_we_o    = reg_we;
    assign fault_o     = (state == S_FAULT);

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed bench with an instruction-level reference model for core_sequencer
module tb_core_sequencer;

    localparam int TO = 4;

    logic        clk;
    logic        reset_i, run_i, mem_ack_i;
    logic [15:0] mem_rdata_i;
    logic        mem_req_o, mem_we_o, reg_we_o, fault_o;
    logic [15:0] mem_addr_o, mem_wdata_o, instr_o, load_data_o, pc_o;
    logic [1:0]  next_pc_sel_i;
    logic        reg_in_source_i, reg_in_en_i, d_we_i, d_addr_sel_i;
    logic [15:0] addr_i, reg_a_i, reg_b_i;

    int total = 0;
    int bad   = 0;

    core_sequencer #(.RESET_PC(16'h0000), .TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_i(reset_i), .run_i(run_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .instr_o(instr_o), .next_pc_sel_i(next_pc_sel_i), .reg_in_source_i(reg_in_source_i),
        .reg_in_en_i(reg_in_en_i), .d_we_i(d_we_i), .d_addr_sel_i(d_addr_sel_i),
        .addr_i(addr_i), .reg_a_i(reg_a_i), .reg_b_i(reg_b_i), .reg_we_o(reg_we_o),
        .load_data_o(load_data_o), .pc_o(pc_o), .fault_o(fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rtab(input logic [1:0] s);
        case (s)
            2'd0:    return 16'h4000;
            2'd1:    return 16'h0200;
            2'd2:    return 16'hFFFE;
            default: return 16'h0040;
        endcase
    endfunction

    function automatic logic [15:0] btab(input logic [1:0] s);
        case (s)
            2'd0:    return 16'h5A5A;
            2'd1:    return 16'h1234;
            2'd2:    return 16'h0F0F;
            default: return 16'hFFFF;
        endcase
    endfunction

    // Bench ISA: [15:13] op (0 ADD, 1 LD abs, 2 LD reg, 3 ST abs, 4 ST reg, 5 BRZ taken, 6 JMP reg, 7 BRZ not taken)
    always_comb begin
        addr_i          = {{3{instr_o[12]}}, instr_o[12:0]};
        reg_a_i         = rtab(instr_o[1:0]);
        reg_b_i         = btab(instr_o[3:2]);
        next_pc_sel_i   = 2'b00;
        reg_in_source_i = 1'b0;
        reg_in_en_i     = 1'b0;
        d_we_i          = 1'b0;
        d_addr_sel_i    = 1'b0;
        case (instr_o[15:13])
            3'd0: reg_in_en_i = 1'b1;
            3'd1: begin reg_in_source_i = 1'b1; reg_in_en_i = 1'b1; end
            3'd2: begin reg_in_source_i = 1'b1; reg_in_en_i = 1'b1; d_addr_sel_i = 1'b1; end
            3'd3: d_we_i = 1'b1;
            3'd4: begin d_we_i = 1'b1; d_addr_sel_i = 1'b1; end
            3'd5: next_pc_sel_i = 2'b01;
            3'd6: next_pc_sel_i = 2'b10;
            default: next_pc_sel_i = 2'b00;
        endcase
    end

    logic [15:0] mem [logic [15:0]];
    int waits = 0;
    int wcnt  = 0;
    bit no_ack = 0;
    bit force_ack = 0;

    function automatic logic [15:0] rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    // Memory responder: ack after `waits` extra cycles, driven 1 time unit after the edge.
    always @(posedge clk) begin
        if (mem_req_o && mem_ack_i && mem_we_o && !reset_i) mem[mem_addr_o] = mem_wdata_o;
        #1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 16'h0000;
        if (force_ack) begin
            mem_ack_i = 1'b1;
        end else if (mem_req_o && !no_ack) begin
            if (wcnt >= waits) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rd(mem_addr_o);
                wcnt        = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } bus_t;

    bus_t        dq[$];
    bus_t        ent;
    bit          chk_on = 0;
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_ir, m_w, m_a, m_exp_ld;
    bit          m_ir_chk = 0, m_pend = 0, m_pend_ld = 0, m_fault = 0;
    int          m_wait = 0;

    // Reference model: executes each instruction architecturally when its fetch completes,
    // then checks the bus traffic, write strobes and fault behaviour cycle by cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_fault", 40'(fault_o), 40'(m_fault));
            if (m_ir_chk) begin
                chk("m_instr", 40'(instr_o), 40'(m_ir));
                m_ir_chk = 0;
            end
            if (!mem_req_o) begin
                chk("m_idle_bus", 40'({mem_we_o, mem_addr_o, mem_wdata_o}), 40'(0));
            end else if (m_fault) begin
                chk("m_req_in_fault", 40'(mem_req_o), 40'(0));
            end else if (dq.size() == 0) begin
                chk("m_fetch_bus", 40'({mem_we_o, mem_addr_o}), 40'({1'b0, m_pc}));
                chk("m_fetch_pc", 40'(pc_o), 40'(m_pc));
                chk("m_regwe_missing", 40'(m_pend), 40'(0));
                if (mem_ack_i && !reset_i) begin
                    m_w = rd(m_pc);
                    m_a = {{3{m_w[12]}}, m_w[12:0]};
                    m_ir = m_w;
                    m_ir_chk = 1;
                    ent = '0;
                    case (m_w[15:13])
                        3'd0: begin m_pend = 1; m_pc = m_pc + 16'd1; end
                        3'd1: begin ent.addr = m_a; dq.push_back(ent); m_pc = m_pc + 16'd1; end
                        3'd2: begin ent.addr = rtab(m_w[1:0]); dq.push_back(ent); m_pc = m_pc + 16'd1; end
                        3'd3: begin
                            ent.we = 1'b1; ent.addr = m_a; ent.wdata = btab(m_w[3:2]);
                            dq.push_back(ent); m_pc = m_pc + 16'd1;
                        end
                        3'd4: begin
                            ent.we = 1'b1; ent.addr = rtab(m_w[1:0]); ent.wdata = btab(m_w[3:2]);
                            dq.push_back(ent); m_pc = m_pc + 16'd1;
                        end
                        3'd5: m_pc = m_pc + m_a;
                        3'd6: m_pc = rtab(m_w[1:0]);
                        default: m_pc = m_pc + 16'd1;
                    endcase
                end
            end else begin
                chk("m_data_bus", 40'({mem_we_o, mem_addr_o}), 40'({dq[0].we, dq[0].addr}));
                if (dq[0].we) chk("m_store_data", 40'(mem_wdata_o), 40'(dq[0].wdata));
                if (mem_ack_i && !reset_i) begin
                    ent = dq.pop_front();
                    if (!ent.we) begin
                        m_pend    = 1;
                        m_pend_ld = 1;
                        m_exp_ld  = rd(ent.addr);
                    end
                end
            end
            if (reg_we_o) begin
                chk("m_regwe_expected", 40'(m_pend), 40'(1));
                if (m_pend_ld) chk("m_load_data", 40'(load_data_o), 40'(m_exp_ld));
                m_pend    = 0;
                m_pend_ld = 0;
            end
            if (mem_req_o && !mem_ack_i) m_wait++;
            else                         m_wait = 0;
            if (m_wait == TO) m_fault = 1;
            if (reset_i) begin
                m_pc = 16'h0000; dq.delete(); m_pend = 0; m_pend_ld = 0;
                m_fault = 0; m_wait = 0; m_ir_chk = 0;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    logic [15:0] fpc [5] = '{16'h0003, 16'h0200, 16'h0201, 16'hFFFE, 16'h0001};

    initial begin
        reset_i = 1; run_i = 0; mem_ack_i = 0; mem_rdata_i = 16'h0000;
        mem[16'h0000] = 16'h0000;
        mem[16'h0001] = 16'h2123;
        mem[16'h0002] = 16'h8000;
        mem[16'h0003] = 16'hC001;
        mem[16'h0200] = 16'hE000;
        mem[16'h0201] = 16'hC002;
        mem[16'hFFFE] = 16'hA003;
        mem[16'h0123] = 16'hBEEF;
        step(2);
        chk("rst_pc", 40'(pc_o), 40'(16'h0000));
        chk("rst_instr", 40'(instr_o), 40'(0));
        chk("rst_load", 40'(load_data_o), 40'(0));
        chk("rst_bus", 40'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}), 40'(0));
        chk("rst_regwe", 40'(reg_we_o), 40'(0));
        chk("rst_fault", 40'(fault_o), 40'(0));
        chk_on = 1; reset_i = 0; run_i = 1;

        step;
        chk("add_fetch", 40'({mem_req_o, mem_we_o, mem_addr_o}), 40'({2'b10, 16'h0000}));
        step;
        chk("add_regwe", 40'(reg_we_o), 40'(1));
        chk("add_exec_pc", 40'(pc_o), 40'(16'h0000));
        chk("add_exec_req", 40'(mem_req_o), 40'(0));
        step;
        chk("add_pc_next", 40'(pc_o), 40'(16'h0001));
        chk("add_next_fetch", 40'({mem_req_o, mem_addr_o}), 40'({1'b1, 16'h0001}));
        waits = 2;

        step;
        chk("ld_exec_regwe", 40'(reg_we_o), 40'(0));
        chk("ld_instr", 40'(instr_o), 40'(16'h2123));
        for (int i = 0; i < 3; i++) begin
            step;
            chk("ld_mem_bus", 40'({mem_req_o, mem_we_o, mem_addr_o}), 40'({2'b10, 16'h0123}));
        end
        step;
        chk("ld_wb_regwe", 40'(reg_we_o), 40'(1));
        chk("ld_wb_data", 40'(load_data_o), 40'(16'hBEEF));
        chk("ld_wb_req", 40'(mem_req_o), 40'(0));
        waits = 0;
        step;
        chk("ld_pc", 40'(pc_o), 40'(16'h0002));

        step(2);
        chk("st_mem_bus", 40'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}),
            40'({2'b11, 16'h4000, 16'h5A5A}));
        chk("st_regwe", 40'(reg_we_o), 40'(0));
        step;

        for (int i = 0; i < 5; i++) begin
            chk("br_pc", 40'(pc_o), 40'(fpc[i]));
            chk("br_fetch", 40'({mem_req_o, mem_addr_o}), 40'({1'b1, fpc[i]}));
            step;
            chk("br_exec_regwe", 40'(reg_we_o), 40'(0));
            step;
        end

        chk("ld2_mem", 40'({mem_req_o, mem_we_o, mem_addr_o}), 40'({2'b10, 16'h0123}));
        run_i = 0;
        step;
        chk("ld2_wb_regwe", 40'(reg_we_o), 40'(1));
        chk("ld2_wb_data", 40'(load_data_o), 40'(16'hBEEF));
        step;
        chk("halt_req", 40'({mem_req_o, mem_addr_o}), 40'(0));
        chk("halt_pc", 40'(pc_o), 40'(16'h0002));

        waits = 2; run_i = 1;
        step;
        chk("wfetch_req", 40'({mem_req_o, mem_addr_o}), 40'({1'b1, 16'h0002}));
        reset_i = 1;
        step;
        chk("mid_rst_req", 40'(mem_req_o), 40'(0));
        chk("mid_rst_pc", 40'(pc_o), 40'(16'h0000));
        reset_i = 0; run_i = 0; force_ack = 1;
        step;
        force_ack = 0;
        chk("stray_ack_req", 40'(mem_req_o), 40'(0));
        step;
        chk("stray_ack_halt", 40'({mem_req_o, fault_o, pc_o}), 40'(0));

        no_ack = 1; run_i = 1;
        for (int i = 0; i < TO; i++) begin
            step;
            chk("to_req", 40'({mem_req_o, fault_o, mem_addr_o}), 40'({2'b10, 16'h0000}));
        end
        step;
        chk("to_fault", 40'({fault_o, mem_req_o, mem_addr_o}), 40'({2'b10, 16'h0000}));
        step(3);
        chk("to_sticky", 40'({fault_o, mem_req_o}), 40'(2'b10));
        reset_i = 1; no_ack = 0; run_i = 0;
        step;
        chk("to_rst", 40'({fault_o, mem_req_o, pc_o}), 40'(0));

        reset_i = 0; waits = 1; run_i = 1;
        step(40);
        run_i = 0;
        step(12);
        chk("drain_req", 40'(mem_req_o), 40'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
